// File: rtl/char_term_writer.sv
// Terminal-style writer: turns an ASCII byte stream into character-RAM writes and tracks a text cursor.
// Optional per-line blanking on every line advance is enabled by defining TERM_LINE_CLR_EN.
module char_term_writer #(
  parameter int         COLS       = 100,
  parameter int         ROWS       = 75,
  parameter int         ADDR_W     = 13,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic              pixel_clock,
  input  logic              nSYSPOR,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_we,
  output logic [6:0]        cur_col,
  output logic [6:0]        cur_line,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ONE_A      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] CELLS_LAST = ADDR_W'(COLS * ROWS - 1);
  localparam logic [6:0]        COL_LAST   = 7'(COLS - 1);
  localparam logic [6:0]        LINE_LAST  = 7'(ROWS - 1);
`ifdef TERM_LINE_CLR_EN
  localparam logic [ADDR_W-1:0] LCLR_LAST  = ADDR_W'(COLS - 1);
`endif

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

`ifdef TERM_LINE_CLR_EN
  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LINE_CLR} state_t;
`else
  typedef enum logic [1:0] {S_CLEAR, S_IDLE} state_t;
`endif

  state_t state, state_next;

  logic [ADDR_W-1:0] count, count_d;
  logic [ADDR_W-1:0] row_base, row_base_d;
  logic [6:0]        col_d, line_d;
  logic              we_d, ready_d, busy_d;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        data_d;

  logic              accept, is_print, line_adv;
  logic [ADDR_W-1:0] cur_addr, base_inc;
  logic [6:0]        line_inc;

  // row_base tracks cur_line*COLS incrementally so no multiplier is needed
  always_comb begin
    accept   = in_valid && in_ready;
    is_print = (in_data >= 8'h20) && (in_data <= 8'h7E);
    cur_addr = row_base + {{(ADDR_W-7){1'b0}}, cur_col};
    line_adv = accept && ((is_print && (cur_col == COL_LAST)) || (in_data == CH_LF));
    if (cur_line == LINE_LAST) begin
      line_inc = '0;
      base_inc = '0;
    end else begin
      line_inc = cur_line + 7'd1;
      base_inc = row_base + COLS_A;
    end
  end

  always_ff @(posedge pixel_clock or negedge nSYSPOR) begin
    if (!nSYSPOR) state <= S_CLEAR;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_CLEAR: if (count == CELLS_LAST) state_next = S_IDLE;
      S_IDLE: begin
        if (accept && (in_data == CH_FF)) state_next = S_CLEAR;
`ifdef TERM_LINE_CLR_EN
        else if (line_adv) state_next = S_LINE_CLR;
`endif
      end
`ifdef TERM_LINE_CLR_EN
      S_LINE_CLR: if (count == LCLR_LAST) state_next = S_IDLE;
`endif
      default: state_next = S_CLEAR;
    endcase
  end

  always_comb begin
    count_d    = count;
    row_base_d = row_base;
    col_d      = cur_col;
    line_d     = cur_line;
    we_d       = 1'b0;
    addr_d     = ram_addr;
    data_d     = ram_data;
    ready_d    = (state_next == S_IDLE);
    busy_d     = (state_next != S_IDLE);
    case (state)
      S_CLEAR: begin
        we_d    = 1'b1;
        addr_d  = count;
        data_d  = BLANK_CHAR;
        count_d = count + ONE_A;
        if (count == CELLS_LAST) begin
          count_d    = '0;
          row_base_d = '0;
          col_d      = '0;
          line_d     = '0;
        end
      end
      S_IDLE: begin
        if (accept) begin
          if (is_print) begin
            we_d   = 1'b1;
            addr_d = cur_addr;
            data_d = in_data;
            if (cur_col == COL_LAST) begin
              col_d      = '0;
              line_d     = line_inc;
              row_base_d = base_inc;
              count_d    = '0;
            end else begin
              col_d = cur_col + 7'd1;
            end
          end else begin
            case (in_data)
              CH_CR: col_d = '0;
              CH_LF: begin
                line_d     = line_inc;
                row_base_d = base_inc;
                count_d    = '0;
              end
              CH_BS: begin
                if (cur_col != '0) begin
                  col_d  = cur_col - 7'd1;
                  we_d   = 1'b1;
                  addr_d = cur_addr - ONE_A;
                  data_d = BLANK_CHAR;
                end
              end
              CH_FF: begin
                count_d    = '0;
                row_base_d = '0;
                col_d      = '0;
                line_d     = '0;
              end
              default: ;
            endcase
          end
        end
      end
`ifdef TERM_LINE_CLR_EN
      // row_base already points at the new line when this state starts
      S_LINE_CLR: begin
        we_d    = 1'b1;
        addr_d  = row_base + count;
        data_d  = BLANK_CHAR;
        count_d = (count == LCLR_LAST) ? '0 : count + ONE_A;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge pixel_clock or negedge nSYSPOR) begin
    if (!nSYSPOR) begin
      count    <= '0;
      row_base <= '0;
      cur_col  <= '0;
      cur_line <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b1;
    end else begin
      count    <= count_d;
      row_base <= row_base_d;
      cur_col  <= col_d;
      cur_line <= line_d;
      ram_we   <= we_d;
      ram_addr <= addr_d;
      ram_data <= data_d;
      in_ready <= ready_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_char_term_writer.sv
// Directed bench for char_term_writer: clear sequence, text/control bytes, wrap, form feed and reset mid-clear.
// Expected values are hand-computed for the default 100x75 screen.
module tb_char_term_writer;

  logic        pixel_clock;
  logic        nSYSPOR;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_we;
  logic [6:0]  cur_col;
  logic [6:0]  cur_line;
  logic        busy;

  int checks = 0;
  int errors = 0;

  char_term_writer #(.COLS(100), .ROWS(75), .ADDR_W(13), .BLANK_CHAR(8'h20)) dut (
    .pixel_clock(pixel_clock),
    .nSYSPOR    (nSYSPOR),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_we     (ram_we),
    .cur_col    (cur_col),
    .cur_line   (cur_line),
    .busy       (busy)
  );

  initial begin
    pixel_clock = 1'b0;
    forever #5 pixel_clock = ~pixel_clock;
  end

  // Observe a blanking run: each write must hit address n (n = write index) with 0x20.
  task automatic watch_clear(input int stop_at, output int nwrites, output int nbad, output int nlow);
    int guard = 0;
    nwrites = 0; nbad = 0; nlow = 0;
    while (nwrites < stop_at && guard < 8000) begin
      @(negedge pixel_clock);
      guard++;
      if (ram_we === 1'b1) begin
        if (ram_addr !== 13'(nwrites) || ram_data !== 8'h20) nbad++;
        if (in_ready === 1'b0) nlow++;
        nwrites++;
      end else if (nwrites > 0) begin
        break;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance with the write outputs of that cycle.
  task automatic send(input logic [7:0] b, output logic we, output logic [12:0] a, output logic [7:0] d);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 9000) begin
      @(negedge pixel_clock);
      guard++;
    end
    checks++;
    if (guard >= 9000) begin
      errors++;
      $display("FAIL send_ready_timeout got in_ready=%0b want 1", in_ready);
    end
    in_data = b; in_valid = 1'b1;
    @(negedge pixel_clock);
    we = ram_we; a = ram_addr; d = ram_data;
    in_valid = 1'b0;
  endtask

  task automatic put(input logic [7:0] b, input int n);
    logic we; logic [12:0] a; logic [7:0] d;
    for (int i = 0; i < n; i++) send(b, we, a, d);
  endtask

  task automatic test_reset;
    int nw, nb, nl;
    nSYSPOR = 1'b0; in_valid = 1'b1; in_data = 8'h41;
    repeat (3) @(negedge pixel_clock);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b want 0", in_ready); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we got %0b want 0", ram_we); end
    checks++; if (ram_addr !== 13'd0) begin errors++; $display("FAIL rst_ram_addr got %0d want 0", ram_addr); end
    checks++; if (ram_data !== 8'h00) begin errors++; $display("FAIL rst_ram_data got %0h want 0", ram_data); end
    checks++; if (cur_col !== 7'd0 || cur_line !== 7'd0) begin errors++; $display("FAIL rst_cursor got %0d,%0d want 0,0", cur_col, cur_line); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %0b want 1", busy); end
    in_valid = 1'b0; nSYSPOR = 1'b1;
    watch_clear(7500, nw, nb, nl);
    checks++; if (nw != 7500) begin errors++; $display("FAIL clr_writes got %0d want 7500", nw); end
    checks++; if (nb != 0) begin errors++; $display("FAIL clr_addr_data got %0d bad want 0", nb); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL clr_done got busy=%0b ready=%0b want 0,1", busy, in_ready); end
    @(negedge pixel_clock);
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL clr_we_end got %0b want 0", ram_we); end
    checks++; if (cur_col !== 7'd0 || cur_line !== 7'd0) begin errors++; $display("FAIL clr_cursor got %0d,%0d want 0,0", cur_col, cur_line); end
  endtask

  task automatic test_back_to_back;
    in_data = 8'h41; in_valid = 1'b1;
    @(negedge pixel_clock);
    checks++; if (ram_we !== 1'b1 || ram_addr !== 13'd0 || ram_data !== 8'h41) begin errors++; $display("FAIL b2b_A got we=%0b a=%0d d=%0h want 1,0,41", ram_we, ram_addr, ram_data); end
    in_data = 8'h42;
    @(negedge pixel_clock);
    checks++; if (ram_we !== 1'b1 || ram_addr !== 13'd1 || ram_data !== 8'h42) begin errors++; $display("FAIL b2b_B got we=%0b a=%0d d=%0h want 1,1,42", ram_we, ram_addr, ram_data); end
    in_valid = 1'b0;
    checks++; if (cur_col !== 7'd2 || cur_line !== 7'd0) begin errors++; $display("FAIL b2b_cursor got %0d,%0d want 2,0", cur_col, cur_line); end
  endtask

  task automatic test_backspace;
    logic we; logic [12:0] a; logic [7:0] d;
    put(8'h0D, 1); put(8'h0A, 2); put(8'h63, 5);
    checks++; if (cur_col !== 7'd5 || cur_line !== 7'd2) begin errors++; $display("FAIL bs_setup got %0d,%0d want 5,2", cur_col, cur_line); end
    send(8'h08, we, a, d);
    checks++; if (we !== 1'b1 || a !== 13'd204 || d !== 8'h20) begin errors++; $display("FAIL bs_write got we=%0b a=%0d d=%0h want 1,204,20", we, a, d); end
    checks++; if (cur_col !== 7'd4 || cur_line !== 7'd2) begin errors++; $display("FAIL bs_cursor got %0d,%0d want 4,2", cur_col, cur_line); end
  endtask

  task automatic test_cr_lf_bs;
    logic we; logic [12:0] a; logic [7:0] d;
    put(8'h0A, 1); put(8'h64, 1);
    checks++; if (cur_col !== 7'd5 || cur_line !== 7'd3) begin errors++; $display("FAIL crlf_setup got %0d,%0d want 5,3", cur_col, cur_line); end
    send(8'h0D, we, a, d);
    checks++; if (we !== 1'b0 || cur_col !== 7'd0 || cur_line !== 7'd3) begin errors++; $display("FAIL cr got we=%0b cur=%0d,%0d want 0,0,3", we, cur_col, cur_line); end
    send(8'h0A, we, a, d);
    checks++; if (we !== 1'b0 || cur_col !== 7'd0 || cur_line !== 7'd4) begin errors++; $display("FAIL lf got we=%0b cur=%0d,%0d want 0,0,4", we, cur_col, cur_line); end
    send(8'h08, we, a, d);
    checks++; if (we !== 1'b0 || cur_col !== 7'd0 || cur_line !== 7'd4) begin errors++; $display("FAIL bs_col0 got we=%0b cur=%0d,%0d want 0,0,4", we, cur_col, cur_line); end
    send(8'h58, we, a, d);
    checks++; if (we !== 1'b1 || a !== 13'd400 || d !== 8'h58) begin errors++; $display("FAIL x_write got we=%0b a=%0d d=%0h want 1,400,58", we, a, d); end
    checks++; if (cur_col !== 7'd1 || cur_line !== 7'd4) begin errors++; $display("FAIL x_cursor got %0d,%0d want 1,4", cur_col, cur_line); end
  endtask

  task automatic test_ignored;
    logic we; logic [12:0] a; logic [7:0] d;
    send(8'h01, we, a, d);
    checks++; if (we !== 1'b0 || cur_col !== 7'd1 || cur_line !== 7'd4) begin errors++; $display("FAIL ign_01 got we=%0b cur=%0d,%0d want 0,1,4", we, cur_col, cur_line); end
    send(8'h7F, we, a, d);
    checks++; if (we !== 1'b0 || cur_col !== 7'd1 || cur_line !== 7'd4) begin errors++; $display("FAIL ign_7f got we=%0b cur=%0d,%0d want 0,1,4", we, cur_col, cur_line); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ign_ready got ready=%0b busy=%0b want 1,0", in_ready, busy); end
  endtask

  task automatic test_wrap;
    logic we; logic [12:0] a; logic [7:0] d;
    put(8'h0D, 1); put(8'h0A, 70); put(8'h65, 99);
    checks++; if (cur_col !== 7'd99 || cur_line !== 7'd74) begin errors++; $display("FAIL wrap_setup got %0d,%0d want 99,74", cur_col, cur_line); end
    send(8'h5A, we, a, d);
    checks++; if (we !== 1'b1 || a !== 13'd7499 || d !== 8'h5A) begin errors++; $display("FAIL wrap_write got we=%0b a=%0d d=%0h want 1,7499,5a", we, a, d); end
    checks++; if (cur_col !== 7'd0 || cur_line !== 7'd0) begin errors++; $display("FAIL wrap_cursor got %0d,%0d want 0,0", cur_col, cur_line); end
`ifdef TERM_LINE_CLR_EN
    begin
      int nw, nb, nl;
      checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL lclr_start got ready=%0b busy=%0b want 0,1", in_ready, busy); end
      watch_clear(100, nw, nb, nl);
      checks++; if (nw != 100 || nb != 0) begin errors++; $display("FAIL lclr_writes got n=%0d bad=%0d want 100,0", nw, nb); end
    end
`else
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL wrap_ready got ready=%0b busy=%0b want 1,0", in_ready, busy); end
`endif
    send(8'h59, we, a, d);
    checks++; if (we !== 1'b1 || a !== 13'd0 || d !== 8'h59) begin errors++; $display("FAIL wrap_base got we=%0b a=%0d d=%0h want 1,0,59", we, a, d); end
  endtask

  task automatic test_ff_hold_and_reset;
    logic we; logic [12:0] a; logic [7:0] d;
    int nw, nb, nl;
    in_data = 8'h0C; in_valid = 1'b1;
    @(negedge pixel_clock);
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ff_start got ready=%0b busy=%0b want 0,1", in_ready, busy); end
    in_data = 8'h51;
    watch_clear(7500, nw, nb, nl);
    checks++; if (nw != 7500 || nb != 0) begin errors++; $display("FAIL ff_clear got n=%0d bad=%0d want 7500,0", nw, nb); end
    checks++; if (nl != 7499) begin errors++; $display("FAIL ff_ready_low got %0d want 7499", nl); end
    @(negedge pixel_clock);
    checks++; if (ram_we !== 1'b1 || ram_addr !== 13'd0 || ram_data !== 8'h51) begin errors++; $display("FAIL ff_held got we=%0b a=%0d d=%0h want 1,0,51", ram_we, ram_addr, ram_data); end
    in_valid = 1'b0;
    checks++; if (cur_col !== 7'd1 || cur_line !== 7'd0) begin errors++; $display("FAIL ff_held_cursor got %0d,%0d want 1,0", cur_col, cur_line); end
    send(8'h0C, we, a, d);
    watch_clear(3000, nw, nb, nl);
    checks++; if (nw != 3000 || nb != 0) begin errors++; $display("FAIL part_clear got n=%0d bad=%0d want 3000,0", nw, nb); end
    nSYSPOR = 1'b0; in_valid = 1'b1; in_data = 8'h41;
    #1;
    checks++; if (ram_we !== 1'b0 || ram_addr !== 13'd0 || ram_data !== 8'h00) begin errors++; $display("FAIL mid_rst_ram got we=%0b a=%0d d=%0h want 0,0,0", ram_we, ram_addr, ram_data); end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL mid_rst_ctl got ready=%0b busy=%0b want 0,1", in_ready, busy); end
    repeat (3) @(negedge pixel_clock);
    checks++; if (ram_we !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_hold got we=%0b ready=%0b want 0,0", ram_we, in_ready); end
    in_valid = 1'b0; nSYSPOR = 1'b1;
    watch_clear(7500, nw, nb, nl);
    checks++; if (nw != 7500 || nb != 0) begin errors++; $display("FAIL restart_clear got n=%0d bad=%0d want 7500,0", nw, nb); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL restart_done got busy=%0b ready=%0b want 0,1", busy, in_ready); end
    send(8'h4B, we, a, d);
    checks++; if (we !== 1'b1 || a !== 13'd0 || d !== 8'h4B) begin errors++; $display("FAIL restart_write got we=%0b a=%0d d=%0h want 1,0,4b", we, a, d); end
  endtask

  initial begin
    nSYSPOR = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    test_reset();
    test_back_to_back();
    test_backspace();
    test_cr_lf_bs();
    test_ignored();
    test_wrap();
    test_ff_hold_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/char_term_writer.md
Name: char_term_writer

Overview:
- Terminal-style writer that sits directly upstream of the character display stage.
- Accepts an ASCII byte stream over a valid/ready handshake and maintains a text cursor.
- Drives the write port of the character buffer RAM that the character generator reads using char_column/char_line.
- Screen is 100x75 cells (800x600, 8x8 glyphs); address = line*COLS + column.

Parameters:
COLS, 100, characters per line
ROWS, 75, lines per screen
ADDR_W, 13, character RAM address width (must satisfy 2^ADDR_W >= COLS*ROWS)
BLANK_CHAR, 8'h20, code written by clear operations

Ports:
pixel_clock  input  1  single clock for all logic
nSYSPOR  input  1  asynchronous active-low reset
in_data  input  8  ASCII byte
in_valid  input  1  in_data valid
in_ready  output  1  byte accepted on a cycle where in_valid && in_ready
ram_addr  output  ADDR_W  character RAM write address
ram_data  output  8  character RAM write data
ram_we  output  1  one-cycle write strobe
cur_col  output  7  cursor column, 0..COLS-1
cur_line  output  7  cursor line, 0..ROWS-1
busy  output  1  high while a clear sequence is running

Behaviour:
- Interface: one clock, pixel_clock. nSYSPOR is asynchronous, active-low: it resets on assertion and releases synchronously to pixel_clock.
- Reset values:
  - in_ready=0, ram_we=0, ram_addr=0, ram_data=0, cur_col=0, cur_line=0, busy=1.
  - Internal row_base=0. State=CLEAR with clear counter=0.
- All outputs are registered.
- Address generation: no multiplier. row_base holds cur_line*COLS. It increments by COLS on each line advance and returns to 0 on wrap past ROWS-1. Write address = row_base + cur_col.
- State CLEAR:
  - Each cycle: ram_we=1, ram_data=BLANK_CHAR, ram_addr=counter, counter+1.
  - After address COLS*ROWS-1 is written, go to IDLE. Cursor is 0,0 and busy=0.
  - A clear takes exactly COLS*ROWS (7500) write cycles. in_ready=0 throughout.
- State IDLE:
  - in_ready=1. Back-to-back acceptance is allowed (one byte per cycle).
  - On accept at edge N, the decoded action is registered at edge N; its ram_we is visible during cycle N+1. ram_we=0 on any cycle with no write.
  - Byte actions:
    - 0x20..0x7E: write in_data at the current cursor address. Then cur_col+1.
    - 0x20..0x7E with cur_col==COLS-1: cur_col=0 and line advance.
    - 0x0D (CR): cur_col=0, no write.
    - 0x0A (LF): line advance, column unchanged, no write.
    - 0x08 (BS): if cur_col>0, cur_col-1 and write BLANK_CHAR at the new position. At column 0, no action.
    - 0x0C (FF): enter CLEAR (counter=0, cursor to 0,0, busy=1). in_ready drops on the cycle after acceptance.
    - Any other byte: accepted and discarded; no write, cursor unchanged.
- Line advance: cur_line+1. From ROWS-1 it wraps to 0 (no scroll) and row_base returns to 0.
- Simultaneous in_valid with nSYSPOR low: reset dominates; the byte is not accepted.
- Reset mid-clear restarts the full clear after release.
- in_data is sampled only when in_valid && in_ready. in_valid may drop at any time without affecting state.

Optional Feature:
- Macro: TERM_LINE_CLR_EN.
- When defined:
  - Every line advance (LF or column wrap) enters state LINE_CLR.
  - LINE_CLR writes BLANK_CHAR to all COLS cells of the new line: row_base+0 .. row_base+COLS-1, one per cycle.
  - in_ready=0 and busy=1 for those COLS cycles, then return to IDLE.
  - The cursor (with column unchanged for LF, 0 for wrap) is already updated when LINE_CLR starts.
- When undefined: no LINE_CLR state. Line advance is a pure cursor update and stale text remains.

Test Plan:
- Reset release: ram_we high for exactly 7500 cycles, addresses 0..7499, data 0x20. Then busy=0, in_ready=1, cursor 0,0.
- Stream "AB" back-to-back after clear: ram_we on consecutive cycles at addr 0 (0x41) and addr 1 (0x42). cur_col=2.
- Cursor at col 99, line 74, send 0x5A: write at addr 7499. Cursor becomes 0,0 and row_base=0. With TERM_LINE_CLR_EN, 100 blank writes to addr 0..99 follow with in_ready=0.
- Cursor at col 5, line 3, send 0x0D then 0x0A then 0x08: cursor goes 0,3 → 0,4; the BS is ignored (no write). Then send "X": written at addr 400.
- Cursor at col 5, line 2, send 0x08: BLANK_CHAR written at addr 204, cursor 4,2.
- Send 0x0C mid-stream with in_valid held high: in_ready low the next cycle for 7500 cycles. The held byte is accepted only after the clear completes. Assert nSYSPOR low at clear count 3000: outputs reset immediately, and the clear restarts from addr 0 after release.
